// File: rtl/am_tune_ctrl.sv
// Station tuning / seek sequencer: steps the NCO phase increment in 9 kHz channels,
// settles, measures carrier level, and drives audio mute. Optional squelch: SQUELCH_EN.
module am_tune_ctrl #(
    parameter int PHASE_BASE = 709151,
    parameter int PHASE_STEP = 12020,
    parameter int CH_MAX     = 119,
    parameter int CH_DEFAULT = 45,
    parameter int SETTLE_N   = 64,
    parameter int MEAS_LOG2  = 6
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        tune_up,
    input  logic        tune_down,
    input  logic        scan_up,
    input  logic        scan_down,
    input  logic [15:0] demod_in,
    input  logic        demod_tick,
    input  logic [15:0] thresh,
    output logic [25:0] phase_inc,
    output logic [6:0]  chan,
    output logic [15:0] level,
    output logic        mute,
    output logic        busy,
    output logic        locked
);

    localparam int ACC_W  = 16 + MEAS_LOG2;
    localparam int SET_W  = $clog2(SETTLE_N + 1);
    localparam int MEAS_N = 1 << MEAS_LOG2;
    localparam int MEAS_W = MEAS_LOG2 + 1;

    localparam logic [25:0] PI_BASE = 26'(PHASE_BASE);
    localparam logic [25:0] PI_STEP = 26'(PHASE_STEP);
    localparam logic [25:0] PI_TOP  = 26'(PHASE_BASE + CH_MAX * PHASE_STEP);
    localparam logic [25:0] PI_DEF  = 26'(PHASE_BASE + CH_DEFAULT * PHASE_STEP);
    localparam logic [6:0]  CH_TOP  = 7'(CH_MAX);
    localparam logic [6:0]  CH_RST  = 7'(CH_DEFAULT);

`ifdef SQUELCH_EN
    localparam bit SQUELCH = 1'b1;
`else
    localparam bit SQUELCH = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, STEP, SETTLE, MEASURE, DECIDE} state_t;

    state_t            state;
    logic              dir_up;
    logic              scan_mode;
    logic [6:0]        origin;
    logic [25:0]       origin_pi;
    logic [7:0]        scan_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic [MEAS_W-1:0] meas_cnt;
    logic [ACC_W-1:0]  acc;
    logic [2:0]        n_cmd;
    logic [15:0]       level_new;
    logic              below;

    assign n_cmd     = 3'(tune_up) + 3'(tune_down) + 3'(scan_up) + 3'(scan_down);
    assign level_new = acc[ACC_W-1:MEAS_LOG2];
    assign below     = level_new < thresh;

    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= IDLE;
            chan       <= CH_RST;
            phase_inc  <= PI_DEF;
            level      <= '0;
            mute       <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            dir_up     <= 1'b0;
            scan_mode  <= 1'b0;
            origin     <= CH_RST;
            origin_pi  <= PI_DEF;
            scan_cnt   <= '0;
            settle_cnt <= '0;
            meas_cnt   <= '0;
            acc        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mute <= SQUELCH && (level < thresh);
                    if (n_cmd == 3'd1) begin
                        dir_up    <= tune_up | scan_up;
                        scan_mode <= scan_up | scan_down;
                        busy      <= 1'b1;
                        mute      <= 1'b1;
                        state     <= STEP;
                        if (scan_up | scan_down) begin
                            origin    <= chan;
                            origin_pi <= phase_inc;
                            scan_cnt  <= '0;
                            locked    <= 1'b0;
                        end
                    end
                end
                STEP: begin
                    // Incremental retune with wrap at both band edges.
                    if (dir_up) begin
                        if (chan == CH_TOP) begin
                            chan      <= '0;
                            phase_inc <= PI_BASE;
                        end else begin
                            chan      <= chan + 7'd1;
                            phase_inc <= phase_inc + PI_STEP;
                        end
                    end else begin
                        if (chan == '0) begin
                            chan      <= CH_TOP;
                            phase_inc <= PI_TOP;
                        end else begin
                            chan      <= chan - 7'd1;
                            phase_inc <= phase_inc - PI_STEP;
                        end
                    end
                    scan_cnt   <= scan_cnt + 8'd1;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (demod_tick) begin
                        if (settle_cnt == SET_W'(SETTLE_N - 1)) begin
                            state    <= MEASURE;
                            acc      <= '0;
                            meas_cnt <= '0;
                            if (!scan_mode) mute <= 1'b0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    if (demod_tick) begin
                        acc <= acc + ACC_W'(demod_in);
                        if (meas_cnt == MEAS_W'(MEAS_N - 1)) state <= DECIDE;
                        else meas_cnt <= meas_cnt + 1'b1;
                    end
                end
                DECIDE: begin
                    level <= level_new;
                    if (scan_mode && below && (scan_cnt < 8'(CH_MAX + 1))) begin
                        state <= STEP;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        mute  <= SQUELCH && below;
                        if (scan_mode && !below) locked <= 1'b1;
                        // Full band without a carrier: return to where the seek began.
                        if (scan_mode && below) begin
                            chan      <= origin;
                            phase_inc <= origin_pi;
                            locked    <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
